// File: rtl/mux_stim_pkg.sv
// Shared definitions for the muxtwo stimulus generator: FSM states,
// LFSR geometry, feedback taps and the default (non-zero) seed.
package mux_stim_pkg;

    localparam int LFSR_W = 16;

    // Feedback taps for x^16+x^14+x^13+x^11+1 in right-shift form: bits 0,2,3,5
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

    localparam logic [LFSR_W-1:0] SEED_DEFAULT_VAL = 16'hACE1;

    localparam int A_BIT = 0;
    localparam int B_BIT = 7;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // An all-zero seed would lock the LFSR, so it is replaced by the default
    function automatic logic [LFSR_W-1:0] safe_seed(
        input logic [LFSR_W-1:0] seed_val,
        input logic [LFSR_W-1:0] dflt
    );
        return (seed_val == '0) ? dflt : seed_val;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous step and seed load; load has
// priority over step and a zero load value is substituted by SEED_DEFAULT.
module lfsr16
    import mux_stim_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = SEED_DEFAULT_VAL
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] q_reg;
    logic [LFSR_W-1:0] q_next;
    logic [LFSR_W-1:0] tap_bits;
    logic              fb;

    genvar gi;
    generate
        for (gi = 0; gi < LFSR_W; gi = gi + 1) begin : g_tap
            assign tap_bits[gi] = q_reg[gi] & LFSR_TAPS[gi];
        end
    endgenerate

    assign fb = ^tap_bits;

    always_comb begin
        q_next = q_reg;
        if (load) begin
            q_next = safe_seed(load_val, SEED_DEFAULT);
        end else if (step) begin
            q_next = {fb, q_reg[LFSR_W-1:1]};
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= SEED_DEFAULT;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/mux_stim_gen.sv
// Pseudo-random stimulus source for a two-input mux: LFSR data bits on a/b,
// a slowly toggling select on sl, plus run/valid control and a step counter.
module mux_stim_gen
    import mux_stim_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = SEED_DEFAULT_VAL,
    parameter int                SEL_PERIOD   = 100
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              en,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    output logic              a,
    output logic              b,
    output logic              sl,
    output logic              valid,
    output logic [15:0]       pat_cnt
);

    localparam logic [15:0] SEL_LAST = 16'(SEL_PERIOD - 1);

    state_t            state_reg;
    state_t            state_next;
    logic [15:0]       sel_cnt_reg;
    logic [15:0]       sel_cnt_next;
    logic              sl_reg;
    logic              sl_next;
    logic [15:0]       pat_cnt_reg;
    logic [15:0]       pat_cnt_next;
    logic              valid_reg;
    logic              step;
    logic [LFSR_W-1:0] lfsr_q;
    logic              unused_lfsr_bits;

    // Stepping is tied to the current state, so the IDLE->RUN edge never steps
    assign step = (state_reg == RUN) && !seed_load;

    lfsr16 #(
        .SEED_DEFAULT (SEED_DEFAULT)
    ) u_lfsr (
        .clock    (clock),
        .rst_n    (rst_n),
        .step     (step),
        .load     (seed_load),
        .load_val (seed),
        .q        (lfsr_q)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (en)  state_next = RUN;
            RUN:  if (!en) state_next = IDLE;
        endcase
        if (seed_load) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        sel_cnt_next = sel_cnt_reg;
        sl_next      = sl_reg;
        pat_cnt_next = pat_cnt_reg;
        if (seed_load) begin
            sel_cnt_next = '0;
            sl_next      = 1'b0;
            pat_cnt_next = '0;
        end else if (step) begin
            pat_cnt_next = pat_cnt_reg + 16'd1;
            if (sel_cnt_reg == SEL_LAST) begin
                sel_cnt_next = '0;
                sl_next      = ~sl_reg;
            end else begin
                sel_cnt_next = sel_cnt_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            sel_cnt_reg <= '0;
            sl_reg      <= 1'b0;
            pat_cnt_reg <= '0;
            valid_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sel_cnt_reg <= sel_cnt_next;
            sl_reg      <= sl_next;
            pat_cnt_reg <= pat_cnt_next;
            valid_reg   <= (state_next == RUN);
        end
    end

    assign a       = lfsr_q[A_BIT];
    assign b       = lfsr_q[B_BIT];
    assign sl      = sl_reg;
    assign valid   = valid_reg;
    assign pat_cnt = pat_cnt_reg;

    assign unused_lfsr_bits = ^{lfsr_q[LFSR_W-1:B_BIT+1], lfsr_q[B_BIT-1:A_BIT+1]};

endmodule

// File: doc/mux_stim_gen.md
MUX_STIM_GEN -- requirements
Module: mux_stim_gen

Interface
REQ-001 Parameter SEED_DEFAULT, 16'hACE1: LFSR value after reset and substitute for a zero seed.
REQ-002 Parameter SEL_PERIOD, 100: number of RUN cycles between select toggles; legal range 2..65535.
REQ-003 clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  run request; level-sensitive.
REQ-006 seed_load  input  1  one-cycle strobe that loads seed.
REQ-007 seed  input  16  LFSR seed, sampled when seed_load=1.
REQ-008 a  output  1  data bit for the downstream muxtwo a port; equals lfsr[0].
REQ-009 b  output  1  data bit for the downstream muxtwo b port; equals lfsr[7].
REQ-010 sl  output  1  select for the downstream muxtwo sl port; registered.
REQ-011 valid  output  1  high while state is RUN; registered.
REQ-012 pat_cnt  output  16  number of LFSR steps since the last reset or seed load; wraps 65535->0.

Function
REQ-013 The LFSR shall be a 16-bit Fibonacci register, polynomial x^16+x^14+x^13+x^11+1, right-shift form: next = {fb, lfsr[15:1]}, where fb = lfsr[0]^lfsr[2]^lfsr[3]^lfsr[5].
REQ-014 Two FSM states: IDLE and RUN.
  - IDLE->RUN when en=1 and seed_load=0.
  - RUN->IDLE when en=0.
REQ-015 In RUN, with seed_load=0:
  - LFSR advances exactly one step per cycle.
  - pat_cnt increments by 1.
  - sel_cnt (16 bits) increments.
REQ-016 When sel_cnt = SEL_PERIOD-1 in a RUN cycle:
  - sel_cnt wraps to 0.
  - sl inverts in the same edge.
  - sl therefore has a period of 2*SEL_PERIOD RUN cycles.
REQ-017 In IDLE, the LFSR, sel_cnt, sl and pat_cnt shall hold; a, b and sl shall remain stable.
REQ-018 The IDLE->RUN transition cycle shall not step the LFSR; the first step occurs on the first edge with state RUN; valid rises on that transition edge.
REQ-019 seed_load=1 in any state shall:
  - load the LFSR with seed, or with SEED_DEFAULT when seed=0 (prevents lock-up);
  - clear sel_cnt, sl and pat_cnt;
  - cause no LFSR step that cycle.
REQ-020 seed_load and en both high: the load wins. State goes to or stays IDLE that cycle, and RUN is entered on the next cycle if en is still 1.
REQ-021 The LFSR shall never hold 0; the sequence period shall be 65535 steps.
REQ-022 a and b shall come directly from LFSR flops, with no combinational path from any input to any output.

Reset
REQ-023 While rst_n=0, regardless of clock:
  - lfsr=SEED_DEFAULT, so a=1 and b=1;
  - sl=0, valid=0, pat_cnt=0, sel_cnt=0;
  - state=IDLE.
REQ-024 Reset asserted mid-RUN shall abort immediately to the reset values; after rst_n deasserts, operation resumes only through REQ-014.

Structure
REQ-025 A shared package mux_stim_pkg shall hold:
  - the state enum (IDLE, RUN);
  - the LFSR width (16), tap constants and SEED_DEFAULT value.
REQ-026 One sub-module, lfsr16, shall implement the step and load logic (ports: clock, rst_n, step, load, load_val, q). The FSM, sel_cnt and pat_cnt shall live in mux_stim_gen.

Verification
REQ-027 Reset, en=0 -> a=1, b=1, sl=0, valid=0, pat_cnt=0; all hold for 20 cycles.
REQ-028 en=1 from reset -> valid=1 after 1 edge; after the first step, lfsr=16'h5670, a=0, b=0, pat_cnt=1.
REQ-029 SEL_PERIOD=4, en held high -> sl toggles every 4 RUN cycles: 0,0,0,0,1,1,1,1,0...; 65535 steps return lfsr to 16'hACE1 with pat_cnt=65535.
REQ-030 seed_load=1 with seed=0, en=1 in the same cycle -> lfsr=16'hACE1, pat_cnt=0, sl=0, no step; stepping resumes one cycle later.
REQ-031 en dropped for 10 cycles mid-RUN -> a, b, sl and pat_cnt are frozen and valid=0; the sequence continues with no skipped step when en returns.
REQ-032 rst_n pulsed low for less than one clock period mid-RUN -> outputs reach reset values asynchronously; valid=0 until en is applied again.
